// File: rtl/aes_pkg.sv
// Shared AES definitions: state and word types, the inverse S-box table,
// and the FSM encoding used by the column-serial inverse SubBytes stage.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } inv_sub_state_e;

    // Inverse S-box, indexed by the substituted byte value.
    localparam logic [7:0] AES_INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte in, one byte out.
// Shared with the key-expansion inverse path.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    assign sub_val = AES_INV_SBOX[byte_val];

endmodule

// File: rtl/aes_inv_subbytes_seq.sv
// AES inverse SubBytes stage with valid/ready handshakes on both sides.
// Default build: four inv_sbox instances substitute one column per cycle
// (4 BUSY cycles per state). Define AES_INV_SUB_FAST_EN to substitute all
// 16 bytes on accept with 16 instances (result valid the next cycle).
module aes_inv_subbytes_seq
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [127:0] data_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic [127:0] data_o,
    output logic         valid_o,
    input  logic         ready_i
);

    inv_sub_state_e state_q;
    state_t         buf_q;
    logic           valid_q;
    logic           accept;

    // ready_i -> ready_o is the only combinational input-to-output path;
    // DONE can hand off and accept on the same edge.
    assign ready_o = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign accept  = valid_i && ready_o;
    assign data_o  = buf_q;
    assign valid_o = valid_q;

`ifdef AES_INV_SUB_FAST_EN

    state_t sub_all;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .byte_val (data_i[8*i +: 8]),
            .sub_val  (sub_all[8*i +: 8])
        );
    end

    // Single-cycle FSM: substitute on accept, hold result until handed off.
    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: buf_q is a plain flop bank (not a RAM), so it is reset to give
        // a defined all-zero data_o out of reset.
        if (reset_i) begin
            state_q <= IDLE;
            buf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: all state here uses <= so every branch sees pre-edge values.
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        buf_q   <= sub_all;
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end else if (state_q == DONE && ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`else

    logic [1:0] col_q;
    logic [6:0] col_msb;
    word_t      col_word;
    word_t      sub_word;

    // Column c occupies bits [127-32c -: 32]; 127-32c == {~c, 5'h1f}.
    assign col_msb  = {~col_q, 5'h1f};
    assign col_word = buf_q[col_msb -: 32];

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .byte_val (col_word[8*i +: 8]),
            .sub_val  (sub_word[8*i +: 8])
        );
    end

    // Column-serial FSM: load on accept, substitute one column per BUSY
    // cycle, then hold the result in DONE until downstream takes it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: buf_q is a plain flop bank (not a RAM), so it is reset to give
        // a defined all-zero data_o out of reset.
        if (reset_i) begin
            state_q <= IDLE;
            buf_q   <= '0;
            col_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: all state here uses <= so the column write and the counter
            // increment both act on the pre-edge col_q.
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        buf_q   <= data_i;
                        col_q   <= 2'd0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    buf_q[col_msb -: 32] <= sub_word;
                    col_q                <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (accept) begin
                        buf_q   <= data_i;
                        col_q   <= 2'd0;
                        state_q <= BUSY;
                        valid_q <= 1'b0;
                    end else if (ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    col_q   <= 2'd0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Self-checking bench for aes_inv_subbytes_seq (default and
// AES_INV_SUB_FAST_EN builds). Expected values come from hand-computed
// constants and a GF(2^8) model of the inverse S-box.
module tb_aes_inv_subbytes_seq;

`ifdef AES_INV_SUB_FAST_EN
    // Extra edges after the accepting edge until valid_o is seen.
    localparam int LAT    = 0;
    localparam int PERIOD = 1;
`else
    localparam int LAT    = 4;
    localparam int PERIOD = 5;
`endif

    logic         clk_i;
    logic         reset_i;
    logic [127:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] data_o;
    logic         valid_o;
    logic         ready_i;

    int checks;
    int failures;

    aes_inv_subbytes_seq dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (a != 8'h00 && gmul(a, 8'(c)) == 8'h01) r = 8'(c);
        end
        return r;
    endfunction

    function automatic logic [7:0] model_byte(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return ginv(t);
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = model_byte(s[8*i +: 8]);
        return r;
    endfunction

    // ---------------- drivers ----------------
    // Present d and return #1 after the edge that accepts it.
    task automatic send(input logic [127:0] d);
        int budget;
        budget  = 0;
        data_i  = d;
        valid_i = 1'b1;
        while (!ready_o && budget < 20) begin
            @(posedge clk_i); #1;
            budget++;
        end
        if (!ready_o) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: ready_o=%0b after %0d cycles, required 1", ready_o, budget);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    // Count edges until valid_o is seen (bounded).
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!valid_o && cycles < 50) begin
            @(posedge clk_i); #1;
            cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset_i = 1'b1;
        valid_i = 1'b1;
        ready_i = 1'b0;
        data_i  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (ready_o !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready: got %0b, required 1", ready_o);
            end
            checks++;
            if (valid_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid: got %0b, required 0", valid_o);
            end
            checks++;
            if (data_o !== 128'h0) begin
                failures++;
                $display("FAIL reset_data: got %h, required 0", data_o);
            end
        end
        valid_i = 1'b0;
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_accept: ready_o=%0b valid_o=%0b, required 1/0", ready_o, valid_o);
        end
    endtask

    task automatic test_sixty_three;
        int cyc;
        ready_i = 1'b1;
        send({16{8'h63}});
        wait_valid(cyc);
        checks++;
        if (cyc != LAT || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL latency_63: got %0d cycles (valid_o=%0b), required %0d", cyc, valid_o, LAT);
        end
        checks++;
        if (data_o !== 128'h0) begin
            failures++;
            $display("FAIL data_63: got %h, required 0", data_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL handoff_idle: valid_o=%0b ready_o=%0b, required 0/1", valid_o, ready_o);
        end
    endtask

    task automatic test_ascending;
        int cyc;
        ready_i = 1'b1;
        send(128'h00010203_04050607_08090a0b_0c0d0e0f);
        wait_valid(cyc);
        checks++;
        if (data_o !== 128'h52096ad5_3036a538_bf40a39e_81f3d7fb) begin
            failures++;
            $display("FAIL data_ascending: got %h, required 52096ad53036a538bf40a39e81f3d7fb", data_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_backpressure;
        int cyc;
        logic [127:0] x1;
        logic [127:0] x2;
        logic [127:0] e1;
        logic [127:0] e2;
        x1 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        x2 = 128'h11223344_55667788_99aabbcc_ddeeff00;
        e1 = model_state(x1);
        e2 = model_state(x2);
        ready_i = 1'b0;
        send(x1);
        wait_valid(cyc);
        // Offer a new state while held: it must not be taken.
        data_i  = x2;
        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== e1) begin
                failures++;
                $display("FAIL hold_data[%0d]: valid_o=%0b data_o=%h, required 1/%h", i, valid_o, data_o, e1);
            end
            checks++;
            if (ready_o !== 1'b0) begin
                failures++;
                $display("FAIL hold_ready[%0d]: got %0b, required 0", i, ready_o);
            end
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL release_ready: got %0b, required 1", ready_o);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc != LAT) begin
            failures++;
            $display("FAIL overlap_latency: got %0d cycles, required %0d", cyc, LAT);
        end
        checks++;
        if (data_o !== e2) begin
            failures++;
            $display("FAIL overlap_data: got %h, required %h", data_o, e2);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back;
        logic [127:0] vec [8];
        logic [127:0] exp_q [8];
        int in_idx;
        int out_idx;
        int cycle;
        int last_cycle;
        for (int i = 0; i < 8; i++) begin
            vec[i]   = {$urandom, $urandom, $urandom, $urandom};
            exp_q[i] = model_state(vec[i]);
        end
        ready_i    = 1'b1;
        in_idx     = 0;
        out_idx    = 0;
        cycle      = 0;
        last_cycle = 0;
        while (out_idx < 8 && cycle < 200) begin
            if (valid_o) begin
                checks++;
                if (data_o !== exp_q[out_idx]) begin
                    failures++;
                    $display("FAIL stream_data[%0d]: got %h, required %h", out_idx, data_o, exp_q[out_idx]);
                end
                if (out_idx > 0) begin
                    checks++;
                    if (cycle - last_cycle != PERIOD) begin
                        failures++;
                        $display("FAIL stream_rate[%0d]: got %0d cycles, required %0d", out_idx, cycle - last_cycle, PERIOD);
                    end
                end
                last_cycle = cycle;
                out_idx++;
            end
            if (in_idx < 8) begin
                data_i  = vec[in_idx];
                valid_i = 1'b1;
                if (ready_o) in_idx++;
            end else begin
                valid_i = 1'b0;
            end
            @(posedge clk_i); #1;
            cycle++;
        end
        valid_i = 1'b0;
        checks++;
        if (out_idx != 8) begin
            failures++;
            $display("FAIL stream_count: got %0d results, required 8", out_idx);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_busy;
        int cyc;
        logic [127:0] y;
        y = 128'ha1b2c3d4_e5f60718_293a4b5c_6d7e8f90;
        ready_i = 1'b0;
        send(128'h01020408_10204080_1b366cd8_ab4d9a2f);
`ifndef AES_INV_SUB_FAST_EN
        // Two more edges: columns 0 and 1 written, column 2 in progress.
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
`endif
        #2;
        reset_i = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || data_o !== 128'h0) begin
            failures++;
            $display("FAIL async_reset: valid_o=%0b data_o=%h, required 0/0", valid_o, data_o);
        end
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_ready: got %0b, required 1", ready_o);
        end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        ready_i = 1'b1;
        send(y);
        wait_valid(cyc);
        checks++;
        if (cyc != LAT || data_o !== model_state(y)) begin
            failures++;
            $display("FAIL post_reset: cycles=%0d data_o=%h, required %0d/%h", cyc, data_o, LAT, model_state(y));
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sixty_three();
        test_ascending();
        test_backpressure();
        test_back_to_back();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
